// File: rtl/rs232_pkg.sv
// Shared RS232 definitions: FSM state encoding, parity/stop codes and bit-period rounding.
// Used by the transmit serializer and the future receiver.
package rs232_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int STOP_ONE = 0;
    localparam int STOP_TWO = 1;

    // Clocks per bit, rounded to nearest.
    function automatic int calc_div(input int clk_freq, input int baud_rate);
        return (clk_freq + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/rs232_baud_ticker.sv
// Bit-period counter 0..DIV-1 with synchronous restart; o_bit_tick marks the last
// clock of each bit period.
module rs232_baud_ticker #(
    parameter int DIV = 434,
    parameter int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_bit_tick
);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_restart || r_cnt == LAST)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_bit_tick = (r_cnt == LAST);

endmodule

// File: rtl/rs232_tx_serializer.sv
// RS232 transmitter: accepts one byte per ready level, frames start/data/parity/stop.
// Parity bit support is compiled in only when RS232_TX_PARITY_EN is defined.
module rs232_tx_serializer
    import rs232_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int BYTE_LEN  = 8,
    parameter int PARITY    = 1,
    parameter int STOP_BITS = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_transaction,
    input  logic [7:0] tx_data,
    input  logic       tx_data_ready,
    output logic       tx_data_copied,
    output logic       tx_busy,
    output logic       tx
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);
    localparam logic [2:0] LAST_BIT = 3'(BYTE_LEN - 1);
`ifdef RS232_TX_PARITY_EN
    localparam bit PAR_EN = (PARITY != PARITY_NONE);
`else
    localparam bit PAR_EN = 1'b0 && (PARITY != PARITY_NONE);
`endif

    tx_state_t  r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit_idx;
    logic       r_stop_idx;
    logic       r_armed;
    logic       w_accept;
    logic       w_tick;
    logic       w_par_bit;

    // armed gates acceptance so a held-high ready yields exactly one frame
    assign w_accept = (r_state == ST_IDLE) && tx_transaction && tx_data_ready && r_armed;

    rs232_baud_ticker #(.DIV(DIV)) u_ticker (
        .clk        (clk),
        .rst        (rst),
        .i_restart  (w_accept),
        .o_bit_tick (w_tick)
    );

`ifdef RS232_TX_PARITY_EN
    logic r_par;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_par <= 1'b0;
        else if (r_state == ST_START && w_tick)
            r_par <= (^r_shift) ^ (PARITY == PARITY_ODD);
    end
    assign w_par_bit = r_par;
`else
    assign w_par_bit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_shift        <= '0;
            r_bit_idx      <= '0;
            r_stop_idx     <= 1'b0;
            r_armed        <= 1'b0;
            tx_data_copied <= 1'b0;
            tx_busy        <= 1'b0;
            tx             <= 1'b1;
        end else begin
            tx_data_copied <= 1'b0;
            if (!tx_data_ready)
                r_armed <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    if (w_accept) begin
                        r_state        <= ST_START;
                        r_shift        <= 8'(tx_data[BYTE_LEN-1:0]);
                        r_armed        <= 1'b0;
                        tx_data_copied <= 1'b1;
                        tx_busy        <= 1'b1;
                        tx             <= 1'b0;
                    end
                end
                ST_START: if (w_tick) begin
                    r_state   <= ST_DATA;
                    r_bit_idx <= '0;
                    tx        <= r_shift[0];
                end
                ST_DATA: if (w_tick) begin
                    r_shift <= r_shift >> 1;
                    if (r_bit_idx == LAST_BIT) begin
                        r_state    <= PAR_EN ? ST_PARITY : ST_STOP;
                        tx         <= PAR_EN ? w_par_bit : 1'b1;
                        r_stop_idx <= 1'b0;
                    end else begin
                        r_bit_idx <= r_bit_idx + 1'b1;
                        tx        <= r_shift[1];
                    end
                end
`ifdef RS232_TX_PARITY_EN
                ST_PARITY: if (w_tick) begin
                    r_state    <= ST_STOP;
                    r_stop_idx <= 1'b0;
                    tx         <= 1'b1;
                end
`endif
                ST_STOP: if (w_tick) begin
                    if (r_stop_idx == 1'(STOP_BITS)) begin
                        r_state <= ST_IDLE;
                        tx_busy <= 1'b0;
                    end else begin
                        r_stop_idx <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    tx_busy <= 1'b0;
                    tx      <= 1'b1;
                end
            endcase
        end
    end

endmodule
